// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states, default
// bus widths and the index-width helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitData
    } arb_state_e;

    localparam int unsigned DefAddrW = 20;
    localparam int unsigned DefDataW = 16;

    // Bits needed to index n items; never less than one so a 2-port build stays legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client-side and sd_controller-side signals of the arbiter. The master modport
// is the arbiter's view; the slave modport is the clients' and controller's view.
interface sdram_port_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = sdram_arb_pkg::DefAddrW,
    parameter int unsigned DATA_W    = sdram_arb_pkg::DefDataW
);

    logic [NUM_PORTS-1:0]        i_Port_Req;
    logic [NUM_PORTS-1:0]        i_Port_Write;
    logic [NUM_PORTS*ADDR_W-1:0] i_Port_Address;
    logic [NUM_PORTS*DATA_W-1:0] i_Port_Write_Data;
    logic [NUM_PORTS-1:0]        o_Port_Ack;
    logic [NUM_PORTS-1:0]        o_Port_Error;
    logic [DATA_W-1:0]           o_Port_Read_Data;
    logic                        o_Busy;

    logic                        o_Read_Request;
    logic                        o_Write_Request;
    logic [ADDR_W-1:0]           o_Read_Address;
    logic [ADDR_W-1:0]           o_Write_Address;
    logic [DATA_W-1:0]           o_Write_Data;
    logic                        i_Read_Grant;
    logic                        i_Write_Grant;
    logic                        i_Data_Valid;
    logic [DATA_W-1:0]           i_Read_Data;

    modport master (
        input  i_Port_Req, i_Port_Write, i_Port_Address, i_Port_Write_Data,
        input  i_Read_Grant, i_Write_Grant, i_Data_Valid, i_Read_Data,
        output o_Port_Ack, o_Port_Error, o_Port_Read_Data, o_Busy,
        output o_Read_Request, o_Write_Request, o_Read_Address, o_Write_Address, o_Write_Data
    );

    modport slave (
        output i_Port_Req, i_Port_Write, i_Port_Address, i_Port_Write_Data,
        output i_Read_Grant, i_Write_Grant, i_Data_Valid, i_Read_Data,
        input  o_Port_Ack, o_Port_Error, o_Port_Read_Data, o_Busy,
        input  o_Read_Request, o_Write_Request, o_Read_Address, o_Write_Address, o_Write_Data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request above the last winner,
// wrapping. Holds no state; the pointer register belongs to the caller.
module rr_arbiter import sdram_arb_pkg::*; #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    always_comb begin
        logic            found;
        int unsigned     p;
        logic [IdxW-1:0] pi;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        p       = 0;
        pi      = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            p  = (32'(last_i) + k) % NumReq;
            pi = IdxW'(p);
            if (!found && req_i[pi]) begin
                found     = 1'b1;
                gnt_o[pi] = 1'b1;
                idx_o     = pi;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single sd_controller request/grant port between NUM_PORTS clients,
// one transaction in flight, round-robin selection, optional per-phase timeout.
module sdram_port_arbiter import sdram_arb_pkg::*; #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                  clk,
    input logic                  i_Rst_n,
    sdram_port_arbiter_if.master bus
);

    localparam int unsigned     IdxW      = clog2(NUM_PORTS);
    localparam int unsigned     CntW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast   = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0] LastReset = IdxW'(NUM_PORTS - 1);

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      last_q, last_d;
    logic [IdxW-1:0]      win_idx_q, win_idx_d;
    logic [NUM_PORTS-1:0] win_oh_q, win_oh_d;
    logic                 op_wr_q, op_wr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_req_q, rd_req_d;
    logic                 wr_req_q, wr_req_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_valid;
    logic [ADDR_W-1:0]    pick_addr;
    logic [DATA_W-1:0]    pick_data;
    logic                 timeout_hit;
    logic                 complete;

    // The port acked last cycle still shows its old request; keep it out for one cycle.
    assign eligible  = bus.i_Port_Req & ~ack_q;
    assign pick_addr = bus.i_Port_Address[32'(pick_idx) * ADDR_W +: ADDR_W];
    assign pick_data = bus.i_Port_Write_Data[32'(pick_idx) * DATA_W +: DATA_W];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

    rr_arbiter #(
        .NumReq (NUM_PORTS),
        .IdxW   (IdxW)
    ) u_rr (
        .req_i   (eligible),
        .last_i  (last_q),
        .gnt_o   (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = '0;
        rd_data_d = rd_data_q;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        complete  = 1'b0;

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d   = StReq;
                    win_idx_d = pick_idx;
                    win_oh_d  = pick_oh;
                    op_wr_d   = bus.i_Port_Write[pick_idx];
                    cnt_d     = '0;
                    if (bus.i_Port_Write[pick_idx]) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = pick_addr;
                        wr_data_d = pick_data;
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = pick_addr;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (op_wr_q && bus.i_Write_Grant) begin
                    wr_req_d = 1'b0;
                    complete = 1'b1;
                end else if (!op_wr_q && bus.i_Read_Grant) begin
                    rd_req_d = 1'b0;
                    if (bus.i_Data_Valid) begin
                        rd_data_d = bus.i_Read_Data;
                        complete  = 1'b1;
                    end else begin
                        state_d = StWaitData;
                        cnt_d   = '0;
                    end
                end else if (timeout_hit) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    err_d    = win_oh_q;
                    complete = 1'b1;
                end
            end
            StWaitData: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.i_Data_Valid) begin
                    rd_data_d = bus.i_Read_Data;
                    complete  = 1'b1;
                end else if (timeout_hit) begin
                    err_d    = win_oh_q;
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            state_d = StIdle;
            ack_d   = win_oh_q;
            last_d  = win_idx_q;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= StIdle;
            last_q    <= LastReset;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            op_wr_q   <= 1'b0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            op_wr_q   <= op_wr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_Port_Ack       = ack_q;
    assign bus.o_Port_Error     = err_q;
    assign bus.o_Port_Read_Data = rd_data_q;
    assign bus.o_Busy           = busy_q;
    assign bus.o_Read_Request   = rd_req_q;
    assign bus.o_Write_Request  = wr_req_q;
    assign bus.o_Read_Address   = rd_addr_q;
    assign bus.o_Write_Address  = wr_addr_q;
    assign bus.o_Write_Data     = wr_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized clients and controller around sdram_port_arbiter, checked per cycle
// against a transaction-level round-robin/timeout model.
module tb_sdram_port_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 16;
    localparam int unsigned TO    = 8;
    localparam int unsigned NTXN  = 160;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_port_arbiter #(
        .NUM_PORTS      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    logic [N-1:0]  req, wr;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wdata [N];

    int unsigned   vec_cnt = 0;
    int unsigned   err_cnt = 0;
    int            last_w;
    int            acked;
    logic [AW-1:0] m_wr_addr, m_rd_addr;
    logic [DW-1:0] m_wr_data, m_rd_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ports();
        for (int p = 0; p < N; p++) begin
            bus.i_Port_Address[p*AW +: AW]    = addr[p];
            bus.i_Port_Write_Data[p*DW +: DW] = wdata[p];
        end
        bus.i_Port_Req   = req;
        bus.i_Port_Write = wr;
    endtask

    task automatic ctrl_idle();
        bus.i_Read_Grant  = 1'b0;
        bus.i_Write_Grant = 1'b0;
        bus.i_Data_Valid  = 1'b0;
        bus.i_Read_Data   = DW'($urandom);
    endtask

    task automatic fresh(input int p);
        wr[p]    = 1'($urandom_range(0, 1));
        addr[p]  = AW'($urandom);
        wdata[p] = DW'($urandom);
    endtask

    task automatic new_requests(input bit all_on);
        for (int p = 0; p < N; p++) begin
            if (all_on) begin
                if (!req[p] || p == acked) fresh(p);
                req[p] = 1'b1;
            end else if (p == acked) begin
                req[p] = 1'($urandom_range(0, 1));
                if (req[p]) fresh(p);
            end else if (!req[p] && $urandom_range(0, 2) == 0) begin
                fresh(p);
                req[p] = 1'b1;
            end
        end
        if (req == '0) begin
            int q;
            q = int'($urandom_range(0, N - 1));
            fresh(q);
            req[q] = 1'b1;
        end
        drive_ports();
    endtask

    task automatic check_bus(input string tag, input logic e_rd, input logic e_wr, input logic e_busy);
        check_eq({tag, ".rd_req"},  32'(bus.o_Read_Request),  32'(e_rd));
        check_eq({tag, ".wr_req"},  32'(bus.o_Write_Request), 32'(e_wr));
        check_eq({tag, ".busy"},    32'(bus.o_Busy),          32'(e_busy));
        check_eq({tag, ".ack"},     32'(bus.o_Port_Ack),      32'd0);
        check_eq({tag, ".err"},     32'(bus.o_Port_Error),    32'd0);
        check_eq({tag, ".rd_addr"}, 32'(bus.o_Read_Address),  32'(m_rd_addr));
        check_eq({tag, ".wr_addr"}, 32'(bus.o_Write_Address), 32'(m_wr_addr));
        check_eq({tag, ".wr_data"}, 32'(bus.o_Write_Data),    32'(m_wr_data));
    endtask

    task automatic check_ack(input string tag, input int win, input logic e_err);
        logic [N-1:0] oh;
        oh      = '0;
        oh[win] = 1'b1;
        check_eq({tag, ".ack"},     32'(bus.o_Port_Ack),       32'(oh));
        check_eq({tag, ".err"},     32'(bus.o_Port_Error),     e_err ? 32'(oh) : 32'd0);
        check_eq({tag, ".rd_data"}, 32'(bus.o_Port_Read_Data), 32'(m_rd_data));
        check_eq({tag, ".reqs"},    {30'd0, bus.o_Read_Request, bus.o_Write_Request}, 32'd0);
        check_eq({tag, ".busy"},    32'(bus.o_Busy),           32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".ack"},     32'(bus.o_Port_Ack),       32'd0);
        check_eq({tag, ".err"},     32'(bus.o_Port_Error),     32'd0);
        check_eq({tag, ".rd_data"}, 32'(bus.o_Port_Read_Data), 32'd0);
        check_eq({tag, ".busy"},    32'(bus.o_Busy),           32'd0);
        check_eq({tag, ".reqs"},    {30'd0, bus.o_Read_Request, bus.o_Write_Request}, 32'd0);
        check_eq({tag, ".rd_addr"}, 32'(bus.o_Read_Address),   32'd0);
        check_eq({tag, ".wr_addr"}, 32'(bus.o_Write_Address),  32'd0);
        check_eq({tag, ".wr_data"}, 32'(bus.o_Write_Data),     32'd0);
    endtask

    task automatic model_reset();
        last_w    = N - 1;
        acked     = -1;
        m_wr_addr = '0;
        m_rd_addr = '0;
        m_wr_data = '0;
        m_rd_data = '0;
    endtask

    // One transaction, entered at the observation point where requests were just set up.
    task automatic run_txn();
        logic [N-1:0]  elig;
        logic [DW-1:0] rdat;
        int            win, d, w;
        bit            extra, is_wr, coincide;
        elig = req;
        if (acked >= 0) elig[acked] = 1'b0;
        extra = (elig == '0);
        if (extra) elig = req;
        win      = rr_pick(last_w, elig);
        is_wr    = wr[win];
        rdat     = '0;
        coincide = ($urandom_range(0, 3) == 0);
        ctrl_idle();
        if (extra) begin
            step();
            check_bus("gap", 1'b0, 1'b0, 1'b0);
        end
        if (is_wr) begin
            m_wr_addr = addr[win];
            m_wr_data = wdata[win];
        end else begin
            m_rd_addr = addr[win];
        end
        step();
        d = int'($urandom_range(0, TO + 2));
        for (int n = 0; n < TO; n++) begin
            check_bus(is_wr ? "wr_req" : "rd_req", !is_wr, is_wr, 1'b1);
            ctrl_idle();
            if (n == d) begin
                if (is_wr) begin
                    bus.i_Write_Grant = 1'b1;
                end else begin
                    bus.i_Read_Grant = 1'b1;
                    if (coincide) begin
                        rdat             = DW'($urandom);
                        bus.i_Data_Valid = 1'b1;
                        bus.i_Read_Data  = rdat;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if (is_wr) begin
                    bus.i_Read_Grant = 1'b1;
                    bus.i_Data_Valid = 1'b1;
                end else begin
                    bus.i_Write_Grant = 1'b1;
                end
            end
            step();
            if (n == d) break;
        end
        if (d >= int'(TO)) begin
            check_ack("req_timeout", win, 1'b1);
        end else if (is_wr) begin
            check_ack("wr_done", win, 1'b0);
        end else if (coincide) begin
            m_rd_data = rdat;
            check_ack("rd_fast", win, 1'b0);
        end else begin
            w = int'($urandom_range(0, TO + 2));
            for (int m = 0; m < TO; m++) begin
                check_bus("wait", 1'b0, 1'b0, 1'b1);
                ctrl_idle();
                if (m == w) begin
                    rdat             = DW'($urandom);
                    bus.i_Data_Valid = 1'b1;
                    bus.i_Read_Data  = rdat;
                end
                step();
                if (m == w) break;
            end
            if (w < int'(TO)) begin
                m_rd_data = rdat;
                check_ack("rd_done", win, 1'b0);
            end else begin
                check_ack("wait_timeout", win, 1'b1);
            end
        end
        last_w = win;
        acked  = win;
        ctrl_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int q;
        rst_n = 1'b0;
        req   = '0;
        wr    = '0;
        for (int p = 0; p < N; p++) begin
            addr[p]  = '0;
            wdata[p] = '0;
        end
        drive_ports();
        ctrl_idle();
        model_reset();
        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        step();
        check_zero("post_reset");

        for (int i = 0; i < int'(NTXN); i++) begin
            new_requests(i < 24);
            run_txn();
        end

        // Reset while a read sits in WAIT_DATA.
        q   = (acked + 1) % N;
        req = '0;
        fresh(q);
        wr[q]  = 1'b0;
        req[q] = 1'b1;
        drive_ports();
        m_rd_addr = addr[q];
        step();
        check_bus("rst_rd_req", 1'b1, 1'b0, 1'b1);
        bus.i_Read_Grant = 1'b1;
        step();
        ctrl_idle();
        check_bus("rst_wait", 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        bus.i_Data_Valid = 1'b1;
        step();
        check_zero("held_reset");
        ctrl_idle();
        rst_n = 1'b1;
        model_reset();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            new_requests(1'b1);
            run_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
